tt_um_macros77_subneg_mem: RTL and testbench

External-memory responder for the subneg CPU tile: the device on the far end of the CPU's multiplexed 8-bit bus (LE / MOE / MWE strobes plus shared data bus). It latches the address phase, drives read data while MOE is asserted, captures one write per MWE pulse into a 32-byte register RAM, and mirrors writes to address 0x15 onto a display port. A load mode lets the board preload a program from the pins before the CPU runs.

---
 rtl/tt_um_macros77_subneg_mem.sv | 188 ++++++++++++++++++
 tb/tb_tt_um_macros77_subneg_mem.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_macros77_subneg_mem.sv
// External-memory responder for the subneg CPU tile.
// Answers the CPU's multiplexed bus (LE / MOE / MWE on ui_in, data on uio),
// backs it with a small register RAM, mirrors one address to a display
// register, and offers a pin-driven load mode for preloading programs.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | bus idle, waiting for an address phase or a strobe
// ADDR   | LE high: addr_q follows the bus, last value kept on LE fall
// READ   | MOE high: responder drives uio with the addressed byte
// WRITE  | MWE high: one write landed on entry, waiting for MWE release
// ERR    | MOE and MWE seen together: bus released until both drop
module tt_um_macros77_subneg_mem #(
  parameter int         ADDR_BITS    = 5,
  parameter logic [7:0] DISPLAY_ADDR = 8'h15,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [5:0]           sync_q [SYNC_STAGES];
  logic [5:0]           ctl_s;
  logic                 le_s;
  logic                 moe_s;
  logic                 mwe_s;
  logic                 load_s;
  logic                 lstb_s;
  logic                 lclr_s;
  logic                 lstb_d;
  logic                 load_rise;

  logic [7:0]           addr_q;
  logic [ADDR_BITS-1:0] addr_idx;
  logic                 addr_in_range;
  logic [7:0]           rdata;
  logic                 wr_entry;
  logic                 cpu_wr;
  logic                 disp_wr;

  logic [7:0]           mem [DEPTH];
  logic [7:0]           display_q;
  logic [ADDR_BITS-1:0] load_ptr;
  logic [4:0]           ptr_view;
  logic [7:0]           status;
  logic [7:0]           oe_q;
  logic [7:0]           rd_q;

  // tile enable and the spare input carry no function
  wire unused_inputs = &{1'b0, ena, ui_in[6]};

  // control-input synchronizer chain; uio_in is held stable by the initiator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= ui_in[5:0];
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign ctl_s  = sync_q[SYNC_STAGES-1];
  assign le_s   = ctl_s[0];
  assign moe_s  = ctl_s[1];
  assign mwe_s  = ctl_s[2];
  assign load_s = ctl_s[3];
  assign lstb_s = ctl_s[4];
  assign lclr_s = ctl_s[5];

  // bus FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next-state: load overrides everything, then bus contention, then LE
  always_comb begin
    state_d = state_q;
    if (load_s) begin
      state_d = ST_IDLE;
    end else if (moe_s && mwe_s) begin
      state_d = ST_ERR;
    end else if (state_q == ST_ERR) begin
      // only one strobe can be high here; ERR holds until both have dropped
      state_d = (!moe_s && !mwe_s) ? ST_IDLE : ST_ERR;
    end else if (le_s) begin
      state_d = ST_ADDR;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (moe_s)      state_d = ST_READ;
          else if (mwe_s) state_d = ST_WRITE;
        end
        ST_ADDR:  state_d = ST_IDLE;
        ST_READ:  if (!moe_s) state_d = ST_IDLE;
        ST_WRITE: if (!mwe_s) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  assign addr_in_range = ((addr_q >> ADDR_BITS) == 8'd0);
  assign addr_idx      = addr_q[ADDR_BITS-1:0];
  assign rdata         = addr_in_range ? mem[addr_idx] : 8'h00;

  // a held MWE pulse writes once: only the edge that enters WRITE counts
  assign wr_entry = (state_q != ST_WRITE) && (state_d == ST_WRITE);
  assign cpu_wr   = wr_entry && addr_in_range;
  assign disp_wr  = cpu_wr && (addr_q == DISPLAY_ADDR);

  // address latch: follows the bus for as long as the FSM stays in ADDR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  addr_q <= 8'h00;
    else if (state_d == ST_ADDR) addr_q <= uio_in;
  end

  // previous synchronized load strobe, for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lstb_d <= 1'b0;
    else        lstb_d <= lstb_s;
  end

  assign load_rise = load_s && lstb_s && !lstb_d;

  // load pointer: clear wins over a same-cycle strobe, wraps at the RAM depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 load_ptr <= '0;
    else if (load_s && lclr_s)  load_ptr <= '0;
    else if (load_rise)         load_ptr <= load_ptr + 1'b1;
  end

  // RAM: load writes use the old pointer; CPU writes cannot occur in load mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (load_rise) begin
      mem[load_ptr] <= uio_in;
    end else if (cpu_wr) begin
      mem[addr_idx] <= uio_in;
    end
  end

  // display register mirrors CPU writes to the display address only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       display_q <= 8'h00;
    else if (disp_wr) display_q <= uio_in;
  end

  // read driver registered off the next state so enable and data move together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_q <= 8'h00;
      rd_q <= 8'h00;
    end else if (state_d == ST_READ) begin
      oe_q <= 8'hFF;
      rd_q <= rdata;
    end else begin
      oe_q <= 8'h00;
      rd_q <= 8'h00;
    end
  end

  assign ptr_view = 5'(load_ptr);
  assign status   = {state_q, ptr_view};
  assign uo_out   = ui_in[7] ? status : display_q;
  assign uio_oe   = oe_q;
  assign uio_out  = rd_q;

endmodule

// File: tb/tb_tt_um_macros77_subneg_mem.sv
// Directed bench for the subneg external-memory responder.
// Inputs change and outputs are sampled on the falling clock edge, so
// "N cycles" below means N rising edges after the pin change.
module tb_tt_um_macros77_subneg_mem;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp;
  int n_err;

  tt_um_macros77_subneg_mem dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_view(input logic v);
    ui_in[7] = v;
    #1;
  endtask

  task automatic do_addr(input logic [7:0] a);
    uio_in   = a;
    ui_in[0] = 1'b1;
    tick(5);
    ui_in[0] = 1'b0;
    tick(4);
  endtask

  task automatic do_read(input logic [7:0] a, output logic [7:0] d, output logic [7:0] oe);
    do_addr(a);
    ui_in[1] = 1'b1;
    tick(3);
    d  = uio_out;
    oe = uio_oe;
    ui_in[1] = 1'b0;
    tick(4);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    do_addr(a);
    uio_in   = d;
    ui_in[2] = 1'b1;
    tick(4);
    ui_in[2] = 1'b0;
    tick(4);
  endtask

  task automatic load_enter();
    ui_in[3] = 1'b1;
    tick(3);
  endtask

  task automatic load_exit();
    ui_in[3] = 1'b0;
    tick(3);
  endtask

  task automatic load_clear();
    ui_in[5] = 1'b1;
    tick(3);
    ui_in[5] = 1'b0;
    tick(3);
  endtask

  task automatic load_byte(input logic [7:0] d);
    uio_in   = d;
    ui_in[4] = 1'b1;
    tick(3);
    ui_in[4] = 1'b0;
    tick(3);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    tick(2);
    n_cmp++;
    if (uio_oe !== 8'h00) begin
      n_err++; $display("FAIL reset_oe: got %02h expected 00", uio_oe);
    end
    n_cmp++;
    if (uio_out !== 8'h00) begin
      n_err++; $display("FAIL reset_out: got %02h expected 00", uio_out);
    end
    n_cmp++;
    if (uo_out !== 8'h00) begin
      n_err++; $display("FAIL reset_display: got %02h expected 00", uo_out);
    end
    set_view(1'b1);
    n_cmp++;
    if (uo_out !== 8'h00) begin
      n_err++; $display("FAIL reset_status: got %02h expected 00", uo_out);
    end
    set_view(1'b0);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_load_read();
    load_enter();
    load_clear();
    load_byte(8'h11);
    load_byte(8'h22);
    load_byte(8'h33);
    set_view(1'b1);
    n_cmp++;
    if (uo_out !== 8'h03) begin
      n_err++; $display("FAIL load_ptr3: got %02h expected 03", uo_out);
    end
    set_view(1'b0);
    load_exit();
    do_addr(8'h01);
    ui_in[1] = 1'b1;
    tick(2);
    n_cmp++;
    if (uio_oe !== 8'h00) begin
      n_err++; $display("FAIL read_oe_early: got %02h expected 00", uio_oe);
    end
    tick(1);
    n_cmp++;
    if (uio_oe !== 8'hFF) begin
      n_err++; $display("FAIL read_oe_on: got %02h expected ff", uio_oe);
    end
    n_cmp++;
    if (uio_out !== 8'h22) begin
      n_err++; $display("FAIL read_data_01: got %02h expected 22", uio_out);
    end
    tick(2);
    ui_in[1] = 1'b0;
    tick(2);
    n_cmp++;
    if (uio_oe !== 8'hFF) begin
      n_err++; $display("FAIL read_oe_hold: got %02h expected ff", uio_oe);
    end
    tick(1);
    n_cmp++;
    if (uio_oe !== 8'h00) begin
      n_err++; $display("FAIL read_oe_off: got %02h expected 00", uio_oe);
    end
    tick(2);
  endtask

  task automatic test_write_display();
    logic [7:0] d, oe;
    do_addr(8'h15);
    uio_in   = 8'hA5;
    ui_in[2] = 1'b1;
    tick(3);
    n_cmp++;
    if (uo_out !== 8'hA5) begin
      n_err++; $display("FAIL write_display: got %02h expected a5", uo_out);
    end
    n_cmp++;
    if (uio_oe !== 8'h00) begin
      n_err++; $display("FAIL write_oe: got %02h expected 00", uio_oe);
    end
    uio_in = 8'h5A;
    tick(3);
    ui_in[2] = 1'b0;
    tick(4);
    n_cmp++;
    if (uo_out !== 8'hA5) begin
      n_err++; $display("FAIL write_once_display: got %02h expected a5", uo_out);
    end
    do_read(8'h15, d, oe);
    n_cmp++;
    if (d !== 8'hA5 || oe !== 8'hFF) begin
      n_err++; $display("FAIL write_readback: got %02h/%02h expected a5/ff", d, oe);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] d, oe;
    do_write(8'h40, 8'h77);
    do_read(8'h40, d, oe);
    n_cmp++;
    if (d !== 8'h00) begin
      n_err++; $display("FAIL oor_read: got %02h expected 00", d);
    end
    do_read(8'h00, d, oe);
    n_cmp++;
    if (d !== 8'h11) begin
      n_err++; $display("FAIL oor_alias_byte0: got %02h expected 11", d);
    end
    n_cmp++;
    if (uo_out !== 8'hA5) begin
      n_err++; $display("FAIL oor_display: got %02h expected a5", uo_out);
    end
  endtask

  task automatic test_error();
    logic [7:0] d, oe;
    do_addr(8'h02);
    ui_in[1] = 1'b1;
    tick(4);
    n_cmp++;
    if (uio_oe !== 8'hFF) begin
      n_err++; $display("FAIL err_pre_read_oe: got %02h expected ff", uio_oe);
    end
    uio_in   = 8'hEE;
    ui_in[2] = 1'b1;
    tick(3);
    set_view(1'b1);
    n_cmp++;
    if (uo_out !== 8'h83) begin
      n_err++; $display("FAIL err_status: got %02h expected 83", uo_out);
    end
    n_cmp++;
    if (uio_oe !== 8'h00) begin
      n_err++; $display("FAIL err_oe: got %02h expected 00", uio_oe);
    end
    ui_in[1] = 1'b0;
    ui_in[2] = 1'b0;
    tick(4);
    n_cmp++;
    if (uo_out !== 8'h03) begin
      n_err++; $display("FAIL err_release_status: got %02h expected 03", uo_out);
    end
    set_view(1'b0);
    do_read(8'h02, d, oe);
    n_cmp++;
    if (d !== 8'h33) begin
      n_err++; $display("FAIL err_no_write: got %02h expected 33", d);
    end
  endtask

  task automatic test_load_wrap();
    logic [7:0] d, oe;
    load_enter();
    load_clear();
    for (int i = 0; i < 33; i++) load_byte(8'h80 + 8'(i));
    set_view(1'b1);
    n_cmp++;
    if (uo_out !== 8'h01) begin
      n_err++; $display("FAIL wrap_ptr: got %02h expected 01", uo_out);
    end
    set_view(1'b0);
    n_cmp++;
    if (uo_out !== 8'hA5) begin
      n_err++; $display("FAIL load_display_untouched: got %02h expected a5", uo_out);
    end
    uio_in   = 8'h5C;
    ui_in[4] = 1'b1;
    ui_in[5] = 1'b1;
    tick(3);
    ui_in[4] = 1'b0;
    ui_in[5] = 1'b0;
    tick(3);
    set_view(1'b1);
    n_cmp++;
    if (uo_out !== 8'h00) begin
      n_err++; $display("FAIL clear_priority_ptr: got %02h expected 00", uo_out);
    end
    set_view(1'b0);
    load_exit();
    do_read(8'h00, d, oe);
    n_cmp++;
    if (d !== 8'hA0) begin
      n_err++; $display("FAIL wrap_byte0: got %02h expected a0", d);
    end
    do_read(8'h01, d, oe);
    n_cmp++;
    if (d !== 8'h5C) begin
      n_err++; $display("FAIL clear_strobe_byte1: got %02h expected 5c", d);
    end
    do_read(8'h15, d, oe);
    n_cmp++;
    if (d !== 8'h95) begin
      n_err++; $display("FAIL load_byte15: got %02h expected 95", d);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] d, oe;
    do_addr(8'h01);
    ui_in[1] = 1'b1;
    tick(4);
    n_cmp++;
    if (uio_oe !== 8'hFF || uio_out !== 8'h5C) begin
      n_err++; $display("FAIL rst_pre_read: got %02h/%02h expected ff/5c", uio_oe, uio_out);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (uio_oe !== 8'h00) begin
      n_err++; $display("FAIL rst_async_oe: got %02h expected 00", uio_oe);
    end
    n_cmp++;
    if (uio_out !== 8'h00) begin
      n_err++; $display("FAIL rst_async_out: got %02h expected 00", uio_out);
    end
    ui_in[1] = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    n_cmp++;
    if (uo_out !== 8'h00) begin
      n_err++; $display("FAIL rst_display: got %02h expected 00", uo_out);
    end
    for (int i = 0; i < 32; i++) begin
      do_read(8'(i), d, oe);
      n_cmp++;
      if (d !== 8'h00) begin
        n_err++; $display("FAIL rst_ram[%0d]: got %02h expected 00", i, d);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    ena    = 1'b1;
    rst_n  = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    test_reset();
    test_load_read();
    test_write_display();
    test_out_of_range();
    test_error();
    test_load_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
